// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: arbitrates SPC/USR command ports, enforces SDRAM bank/global timing,
// tracks open banks and drives registered command pins.
module sdram_cmd_sched #(
  parameter int T_RC   = 9,
  parameter int T_RAS  = 6,
  parameter int T_RP   = 3,
  parameter int T_RCD  = 3,
  parameter int T_MRD  = 2,
  parameter int T_DPL  = 2,
  parameter int BURST  = 8,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
) (
  input  logic                   CLK,
  input  logic                   RESET_IN,
  input  logic                   INIT_DONE_IN,
  output logic                   BANK_ACTIVE_OUT,
  input  logic [2:0]             SPC_CMD_OP_IN,
  input  logic [BA_W+ADDR_W-1:0] SPC_CMD_ADDR_IN,
  input  logic [ADDR_W-1:0]      SPC_CMD_DATA_IN,
  input  logic                   SPC_REQ_IN,
  output logic                   SPC_ACK_OUT,
  input  logic [2:0]             USR_CMD_OP_IN,
  input  logic [BA_W+ADDR_W-1:0] USR_CMD_ADDR_IN,
  input  logic [ADDR_W-1:0]      USR_CMD_DATA_IN,
  input  logic                   USR_REQ_IN,
  output logic                   USR_ACK_OUT,
  output logic                   SDRAM_CS_N,
  output logic                   SDRAM_RAS_N,
  output logic                   SDRAM_CAS_N,
  output logic                   SDRAM_WE_N,
  output logic [BA_W-1:0]        SDRAM_BA,
  output logic [ADDR_W-1:0]      SDRAM_A,
  output logic                   ERR_OUT
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_MRS = 3'd1, OP_REF = 3'd2, OP_PRE = 3'd3,
                         OP_ACT = 3'd4, OP_READ = 3'd5, OP_WRITE = 3'd6;
  localparam int NB = 1 << BA_W;
  localparam int CW = 5;
  typedef logic [NB-1:0][CW-1:0] cnt_t;
  cnt_t rcd_q, rcd_d, ras_q, ras_d, rc_q, rc_d, rp_q, rp_d, wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] gbl_q, gbl_d;
  logic [NB-1:0] open_q, open_d;
  logic [3:0] cmd_q, cmd_d;
  logic [BA_W-1:0] ba_q, ba_d, bank;
  logic [ADDR_W-1:0] a_q, a_d, data, col;
  logic [BA_W+ADDR_W-1:0] addr;
  logic [2:0] op;
  logic err_q, err_d, spc_nop, use_spc, use_usr, pall, ok, go, pre_all_ok, ref_ok;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  always_comb begin
    spc_nop = SPC_REQ_IN && SPC_CMD_OP_IN == OP_NOP;
    use_spc = SPC_REQ_IN && !spc_nop;
    use_usr = USR_REQ_IN && INIT_DONE_IN && !use_spc;
    op = use_spc ? SPC_CMD_OP_IN : use_usr ? USR_CMD_OP_IN : OP_NOP;
    addr = use_spc ? SPC_CMD_ADDR_IN : USR_CMD_ADDR_IN;
    data = use_spc ? SPC_CMD_DATA_IN : USR_CMD_DATA_IN;
    bank = addr[ADDR_W +: BA_W];
    pall = addr[10];
    col = addr[ADDR_W-1:0] & ~(ADDR_W'(1) << 10);
    pre_all_ok = 1'b1;
    ref_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      pre_all_ok &= ras_q[i] == '0 && wr_q[i] == '0 && rd_q[i] == '0;
      ref_ok &= rp_q[i] == '0;
    end
    case (op)
      OP_ACT:            ok = rc_q[bank] == '0 && rp_q[bank] == '0;
      OP_READ, OP_WRITE: ok = rcd_q[bank] == '0;
      OP_PRE:            ok = pall ? pre_all_ok : ras_q[bank] == '0 && wr_q[bank] == '0 && rd_q[bank] == '0;
      OP_REF, OP_MRS:    ok = ref_ok;
      default:           ok = 1'b1;
    endcase
    go = op == OP_NOP || (gbl_q == '0 && ok);
    SPC_ACK_OUT = !RESET_IN && (spc_nop || (use_spc && go));
    USR_ACK_OUT = !RESET_IN && use_usr && go;
    for (int i = 0; i < NB; i++) begin
      rcd_d[i] = dec(rcd_q[i]);
      ras_d[i] = dec(ras_q[i]);
      rc_d[i]  = dec(rc_q[i]);
      rp_d[i]  = dec(rp_q[i]);
      wr_d[i]  = dec(wr_q[i]);
      rd_d[i]  = dec(rd_q[i]);
    end
    gbl_d = dec(gbl_q);
    open_d = open_q;
    cmd_d = 4'b0111;
    ba_d = '0;
    a_d = '0;
    err_d = err_q;
    // Counters load T-1 on the issue edge so the dependent command sees a pin gap of T.
    if (go) begin
      case (op)
        OP_MRS: begin
          cmd_d = 4'b0000;
          a_d = data;
          gbl_d = CW'(T_MRD - 1);
          err_d = err_q | (|open_q);
        end
        OP_REF: begin
          cmd_d = 4'b0001;
          gbl_d = CW'(T_RC - 1);
          err_d = err_q | (|open_q);
        end
        OP_PRE: begin
          cmd_d = 4'b0010;
          ba_d = bank;
          a_d[10] = pall;
          if (pall) begin
            open_d = '0;
            gbl_d = CW'(T_RP - 1);
          end else begin
            open_d[bank] = 1'b0;
            rp_d[bank] = CW'(T_RP - 1);
          end
        end
        OP_ACT: begin
          cmd_d = 4'b0011;
          ba_d = bank;
          a_d = addr[ADDR_W-1:0];
          err_d = err_q | open_q[bank];
          open_d[bank] = 1'b1;
          rcd_d[bank] = CW'(T_RCD - 1);
          ras_d[bank] = CW'(T_RAS - 1);
          rc_d[bank] = CW'(T_RC - 1);
        end
        OP_READ: begin
          cmd_d = 4'b0101;
          ba_d = bank;
          a_d = col;
          err_d = err_q | !open_q[bank];
          rd_d[bank] = CW'(BURST - 1);
        end
        OP_WRITE: begin
          cmd_d = 4'b0100;
          ba_d = bank;
          a_d = col;
          err_d = err_q | !open_q[bank];
          wr_d[bank] = CW'(BURST + T_DPL - 1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      cmd_q <= 4'b1111;
      ba_q <= '0;
      a_q <= '0;
      err_q <= 1'b0;
      open_q <= '0;
      gbl_q <= '0;
      rcd_q <= '0;
      ras_q <= '0;
      rc_q <= '0;
      rp_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
      ba_q <= ba_d;
      a_q <= a_d;
      err_q <= err_d;
      open_q <= open_d;
      gbl_q <= gbl_d;
      rcd_q <= rcd_d;
      ras_q <= ras_d;
      rc_q <= rc_d;
      rp_q <= rp_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  assign {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N} = cmd_q;
  assign SDRAM_BA = ba_q;
  assign SDRAM_A = a_q;
  assign ERR_OUT = err_q;
  assign BANK_ACTIVE_OUT = |open_q;
endmodule

// File: tb/tb_sdram_cmd_sched.sv
// tb_sdram_cmd_sched: timestamp-based reference model feeds an expected-pin queue; a monitor
// pops and compares whenever the command pins show a non-NOP command.
module tb_sdram_cmd_sched;
  localparam int T_RC = 9, T_RAS = 6, T_RP = 3, T_RCD = 3, T_MRD = 2, T_DPL = 2, BURST = 8;
  localparam logic [2:0] OP_NOP = 3'd0, OP_MRS = 3'd1, OP_REF = 3'd2, OP_PRE = 3'd3,
                         OP_ACT = 3'd4, OP_READ = 3'd5, OP_WRITE = 3'd6;

  typedef struct { logic [2:0] op; logic [1:0] b; logic [12:0] a; logic [12:0] d; } cmd_s;
  typedef struct { int t; logic [3:0] c; logic [1:0] ba; logic [12:0] a; } pin_s;

  logic CLK = 0, RESET_IN, INIT_DONE_IN, BANK_ACTIVE_OUT;
  logic [2:0] SPC_CMD_OP_IN, USR_CMD_OP_IN;
  logic [14:0] SPC_CMD_ADDR_IN, USR_CMD_ADDR_IN;
  logic [12:0] SPC_CMD_DATA_IN, USR_CMD_DATA_IN;
  logic SPC_REQ_IN, SPC_ACK_OUT, USR_REQ_IN, USR_ACK_OUT;
  logic SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N, ERR_OUT;
  logic [1:0] SDRAM_BA;
  logic [12:0] SDRAM_A;

  sdram_cmd_sched dut (
    .CLK(CLK), .RESET_IN(RESET_IN), .INIT_DONE_IN(INIT_DONE_IN), .BANK_ACTIVE_OUT(BANK_ACTIVE_OUT),
    .SPC_CMD_OP_IN(SPC_CMD_OP_IN), .SPC_CMD_ADDR_IN(SPC_CMD_ADDR_IN), .SPC_CMD_DATA_IN(SPC_CMD_DATA_IN),
    .SPC_REQ_IN(SPC_REQ_IN), .SPC_ACK_OUT(SPC_ACK_OUT),
    .USR_CMD_OP_IN(USR_CMD_OP_IN), .USR_CMD_ADDR_IN(USR_CMD_ADDR_IN), .USR_CMD_DATA_IN(USR_CMD_DATA_IN),
    .USR_REQ_IN(USR_REQ_IN), .USR_ACK_OUT(USR_ACK_OUT),
    .SDRAM_CS_N(SDRAM_CS_N), .SDRAM_RAS_N(SDRAM_RAS_N), .SDRAM_CAS_N(SDRAM_CAS_N), .SDRAM_WE_N(SDRAM_WE_N),
    .SDRAM_BA(SDRAM_BA), .SDRAM_A(SDRAM_A), .ERR_OUT(ERR_OUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  pin_s exp_q[$], obs_q[$];
  cmd_s spc_q[$], usr_q[$];
  bit spc_pres, usr_pres, rnd;
  int act_t[4], pre_t[4], rd_t[4], wr_t[4], gbl_until;
  logic [3:0] open_m;
  bit err_m;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic cmd_s mk(logic [2:0] op, logic [1:0] b, logic [12:0] a, logic [12:0] d);
    cmd_s c;
    c.op = op; c.b = b; c.a = a; c.d = d;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      act_t[i] = -1000; pre_t[i] = -1000; rd_t[i] = -1000; wr_t[i] = -1000;
    end
    gbl_until = -1000;
    open_m = '0;
    err_m = 0;
  endfunction

  function automatic bit pre_ok(int b, int t);
    return t >= act_t[b] + T_RAS && t >= wr_t[b] + BURST + T_DPL && t >= rd_t[b] + BURST;
  endfunction

  // Eligibility: issue cycle t must be at least T after the prior constraining issue.
  function automatic bit ok_m(cmd_s c, int t);
    bit r = 1;
    if (c.op == OP_NOP) return 1;
    if (t < gbl_until) return 0;
    case (c.op)
      OP_ACT: r = t >= act_t[c.b] + T_RC && t >= pre_t[c.b] + T_RP;
      OP_READ, OP_WRITE: r = t >= act_t[c.b] + T_RCD;
      OP_PRE: for (int i = 0; i < 4; i++) if (c.a[10] || i == int'(c.b)) r &= pre_ok(i, t);
      default: for (int i = 0; i < 4; i++) r &= t >= pre_t[i] + T_RP;
    endcase
    return r;
  endfunction

  function automatic pin_s exp_pins(cmd_s c);
    pin_s p;
    p.t = 0; p.ba = c.b; p.a = c.a;
    case (c.op)
      OP_MRS: begin p.c = 4'b0000; p.ba = 0; p.a = c.d; end
      OP_REF: begin p.c = 4'b0001; p.ba = 0; p.a = 0; end
      OP_PRE: begin p.c = 4'b0010; p.a = c.a[10] ? 13'h400 : 13'h000; end
      OP_ACT: p.c = 4'b0011;
      OP_READ: begin p.c = 4'b0101; p.a[10] = 1'b0; end
      default: begin p.c = 4'b0100; p.a[10] = 1'b0; end
    endcase
    return p;
  endfunction

  task automatic issue_m(cmd_s c);
    pin_s p = exp_pins(c);
    p.t = cyc + 1;
    exp_q.push_back(p);
    case (c.op)
      OP_ACT: begin err_m |= open_m[c.b]; open_m[c.b] = 1; act_t[c.b] = cyc; end
      OP_READ: begin err_m |= !open_m[c.b]; rd_t[c.b] = cyc; end
      OP_WRITE: begin err_m |= !open_m[c.b]; wr_t[c.b] = cyc; end
      OP_PRE: if (c.a[10]) begin open_m = '0; gbl_until = cyc + T_RP; end
              else begin open_m[c.b] = 0; pre_t[c.b] = cyc; end
      OP_REF: begin err_m |= |open_m; gbl_until = cyc + T_RC; end
      default: begin err_m |= |open_m; gbl_until = cyc + T_MRD; end
    endcase
  endtask

  task automatic step();
    cmd_s s, u;
    bit snop, sa, ua;
    s = mk(OP_NOP, 0, 0, 0); u = s;
    @(posedge CLK); #2;
    chk("err_out", ERR_OUT, err_m);
    chk("bank_active", BANK_ACTIVE_OUT, |open_m);
    if (!spc_pres && spc_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) spc_pres = 1;
    if (!usr_pres && usr_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) usr_pres = 1;
    if (spc_pres) s = spc_q[0];
    if (usr_pres) u = usr_q[0];
    SPC_REQ_IN = spc_pres;
    USR_REQ_IN = usr_pres;
    SPC_CMD_OP_IN = spc_pres ? s.op : 3'($urandom);
    SPC_CMD_ADDR_IN = spc_pres ? {s.b, s.a} : 15'($urandom);
    SPC_CMD_DATA_IN = spc_pres ? s.d : 13'($urandom);
    USR_CMD_OP_IN = usr_pres ? u.op : 3'($urandom);
    USR_CMD_ADDR_IN = usr_pres ? {u.b, u.a} : 15'($urandom);
    USR_CMD_DATA_IN = usr_pres ? u.d : 13'($urandom);
    #1;
    snop = spc_pres && s.op == OP_NOP;
    sa = snop || (spc_pres && ok_m(s, cyc));
    ua = usr_pres && INIT_DONE_IN && (!spc_pres || snop) && ok_m(u, cyc);
    chk("spc_ack", SPC_ACK_OUT, sa);
    chk("usr_ack", USR_ACK_OUT, ua);
    if (sa && !snop) issue_m(s);
    else if (ua && u.op != OP_NOP) issue_m(u);
    if (sa) begin void'(spc_q.pop_front()); spc_pres = 0; end
    if (ua) begin void'(usr_q.pop_front()); usr_pres = 0; end
  endtask

  task automatic run_phase(string n, int budget);
    int k = 0;
    while ((spc_q.size() > 0 || usr_q.size() > 0 || spc_pres || usr_pres || exp_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    tests++;
    if (k >= budget) begin
      fails++;
      $display("FAIL %s timeout: %0d commands still pending after %0d cycles", n, exp_q.size() + spc_q.size() + usr_q.size(), k);
      exp_q.delete(); spc_q.delete(); usr_q.delete();
      spc_pres = 0; usr_pres = 0;
    end
  endtask

  initial begin : mon
    pin_s p;
    logic [3:0] cur;
    forever begin
      @(posedge CLK); #1;
      if (!RESET_IN) begin
        cur = {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N};
        if (cur != 4'b0111) obs_q.push_back('{cyc, cur, SDRAM_BA, SDRAM_A});
        if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
          p = exp_q.pop_front();
          tests++;
          if ({cur, SDRAM_BA, SDRAM_A} !== {p.c, p.ba, p.a}) begin
            fails++;
            $display("FAIL pins @%0d: got cmd=%b ba=%0d a=%h, expected cmd=%b ba=%0d a=%h",
                     cyc, cur, SDRAM_BA, SDRAM_A, p.c, p.ba, p.a);
          end
        end else if (cur !== 4'b0111) begin
          tests++;
          fails++;
          $display("FAIL unexpected cmd @%0d: got %b, expected NOP 0111", cyc, cur);
        end
      end
    end
  end

  initial begin
    int b;
    RESET_IN = 1; INIT_DONE_IN = 0; rnd = 0; spc_pres = 0; usr_pres = 0;
    SPC_REQ_IN = 0; USR_REQ_IN = 0;
    SPC_CMD_OP_IN = 0; SPC_CMD_ADDR_IN = 0; SPC_CMD_DATA_IN = 0;
    USR_CMD_OP_IN = 0; USR_CMD_ADDR_IN = 0; USR_CMD_DATA_IN = 0;
    model_reset();
    repeat (5) @(posedge CLK);
    #2;
    SPC_REQ_IN = 1; SPC_CMD_OP_IN = OP_REF;
    #1;
    chk("reset pins", {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N}, 4'b1111);
    chk("reset ba/a", {SDRAM_BA, SDRAM_A}, 0);
    chk("reset acks", {SPC_ACK_OUT, USR_ACK_OUT}, 0);
    chk("reset bank_active", BANK_ACTIVE_OUT, 0);
    chk("reset err", ERR_OUT, 0);
    SPC_REQ_IN = 0;
    RESET_IN = 0;
    @(posedge CLK); #1;
    chk("post-reset nop", {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N}, 4'b0111);

    // init sequence: PRE-ALL, REF, REF, MRS
    b = obs_q.size();
    spc_q.push_back(mk(OP_PRE, 0, 13'h400, 0));
    spc_q.push_back(mk(OP_REF, 0, 0, 0));
    spc_q.push_back(mk(OP_REF, 0, 0, 0));
    spc_q.push_back(mk(OP_MRS, 0, 13'h1abc, 13'h033));
    run_phase("init", 100);
    chk("init count", obs_q.size() - b, 4);
    chk("gap pall-ref", obs_q[b+1].t - obs_q[b].t, 3);
    chk("gap ref-ref", obs_q[b+2].t - obs_q[b+1].t, 9);
    chk("gap ref-mrs", obs_q[b+3].t - obs_q[b+2].t, 9);
    chk("mrs A", obs_q[b+3].a, 13'h033);

    INIT_DONE_IN = 1;
    b = obs_q.size();
    usr_q.push_back(mk(OP_ACT, 1, 13'h123, 0));
    usr_q.push_back(mk(OP_READ, 1, 13'h440, 0));
    run_phase("act-read", 100);
    chk("gap act-read", obs_q[b+1].t - obs_q[b].t, 3);
    chk("read A", obs_q[b+1].a, 13'h040);
    chk("read BA", obs_q[b+1].ba, 1);
    chk("bank_active after act", BANK_ACTIVE_OUT, 1);

    b = obs_q.size();
    usr_q.push_back(mk(OP_ACT, 0, 13'h055, 0));
    usr_q.push_back(mk(OP_PRE, 0, 13'h000, 0));
    usr_q.push_back(mk(OP_ACT, 0, 13'h066, 0));
    run_phase("act-pre-act", 100);
    chk("gap act-pre", obs_q[b+1].t - obs_q[b].t, 6);
    chk("gap pre-act", obs_q[b+2].t - obs_q[b+1].t, 3);

    b = obs_q.size();
    spc_q.push_back(mk(OP_PRE, 0, 13'h400, 0));
    spc_q.push_back(mk(OP_REF, 0, 0, 0));
    usr_q.push_back(mk(OP_ACT, 3, 13'h077, 0));
    run_phase("spc priority", 100);
    chk("gap ref-act", obs_q[b+2].t - obs_q[b+1].t, 9);
    chk("act after ref", {obs_q[b+2].c, obs_q[b+2].ba}, {4'b0011, 2'd3});

    chk("err before", ERR_OUT, 0);
    usr_q.push_back(mk(OP_ACT, 2, 13'h0aa, 0));
    run_phase("act b2", 100);
    spc_q.push_back(mk(OP_REF, 0, 0, 0));
    run_phase("ref open", 100);
    chk("err after ref", ERR_OUT, 1);

    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ops[5] = '{OP_NOP, OP_ACT, OP_READ, OP_WRITE, OP_PRE};
      usr_q.push_back(mk(ops[$urandom_range(4)], 2'($urandom), 13'($urandom), 13'($urandom)));
      if (i % 3 == 0) begin
        logic [2:0] sops[4] = '{OP_NOP, OP_REF, OP_MRS, OP_PRE};
        spc_q.push_back(mk(sops[$urandom_range(3)], 2'($urandom), 13'($urandom), 13'($urandom)));
      end
    end
    run_phase("random", 3000);
    chk("err sticky", ERR_OUT, 1);

    rnd = 0;
    usr_q.push_back(mk(OP_WRITE, 1, 13'h000, 0));
    run_phase("write", 100);
    @(posedge CLK); #4;
    RESET_IN = 1;
    #1;
    chk("async reset pins", {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N}, 4'b1111);
    chk("async reset ba/a", {SDRAM_BA, SDRAM_A}, 0);
    chk("async reset bank/err", {BANK_ACTIVE_OUT, ERR_OUT}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
